// File: rtl/reflet_exti_n.sv
// Parametrised external-interrupt controller: pending latch, enable, edge/level mode,
// CPU line mapping, W1C acknowledge, software trigger and priority readout.
// Optional macro REFLET_EXTI_SYNC_EN adds a 2-flop synchroniser on every int_in bit.
module reflet_exti_n #(
  parameter int wordsize = 16,
  parameter int base_addr_size = 16,
  parameter logic [base_addr_size-1:0] base_addr = 16'hFF0C,
  parameter int nb_sources = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  output logic [3:0]                cpu_int,
  input  logic [nb_sources-1:0]     int_in
);

  localparam int idx_w = $clog2(nb_sources + 1);

  logic [base_addr_size-1:0] offset;
  logic [2:0]                reg_idx;
  logic                      sel;
  logic                      wr;

  logic [nb_sources-1:0]     en_reg;
  logic [nb_sources-1:0]     mode_reg;
  logic [2*nb_sources-1:0]   level_reg;
  logic [nb_sources-1:0]     pend;
  logic [nb_sources-1:0]     prev;
  logic [nb_sources-1:0]     s;
  logic [nb_sources-1:0]     set_cond;
  logic [nb_sources-1:0]     w1c_mask;
  logic [nb_sources-1:0]     sw_mask;
  logic [nb_sources-1:0]     pend_next;
  logic [3:0]                cpu_next;
  logic [idx_w-1:0]          active_idx;
  logic [1:0]                best_level;
  logic                      found;

  assign offset  = addr - base_addr;
  assign reg_idx = offset[2:0];
  assign sel     = enable && (addr >= base_addr) && (offset < base_addr_size'(6));
  assign wr      = sel && write_en;

`ifdef REFLET_EXTI_SYNC_EN
  logic [nb_sources-1:0] sync_meta;
  logic [nb_sources-1:0] sync_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= int_in;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;
`else
  assign s = int_in;
`endif

  // Level sources set while high; edge sources only when the previous sample was low.
  assign set_cond  = s & ~(mode_reg & prev);
  assign w1c_mask  = (wr && reg_idx == 3'd3) ? data_in[nb_sources-1:0] : '0;
  assign sw_mask   = (wr && reg_idx == 3'd4) ? data_in[nb_sources-1:0] : '0;
  assign pend_next = (pend & ~w1c_mask) | set_cond | sw_mask;

  always_comb begin
    cpu_next = '0;
    for (int i = 0; i < nb_sources; i++) begin
      if (pend[i] && en_reg[i]) cpu_next[level_reg[2*i +: 2]] = 1'b1;
    end
  end

  // Strict greater-than keeps the lowest index on equal LEVEL values.
  always_comb begin
    active_idx = idx_w'(nb_sources);
    best_level = '0;
    found      = 1'b0;
    for (int i = 0; i < nb_sources; i++) begin
      if (pend[i] && en_reg[i] && (!found || level_reg[2*i +: 2] > best_level)) begin
        found      = 1'b1;
        best_level = level_reg[2*i +: 2];
        active_idx = idx_w'(i);
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (reg_idx)
        3'd0:    data_out[nb_sources-1:0]   = en_reg;
        3'd1:    data_out[nb_sources-1:0]   = mode_reg;
        3'd2:    data_out[2*nb_sources-1:0] = level_reg;
        3'd3:    data_out[nb_sources-1:0]   = pend;
        3'd5:    data_out[idx_w-1:0]        = active_idx;
        default: data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_reg    <= '0;
      mode_reg  <= '0;
      level_reg <= '0;
      pend      <= '0;
      prev      <= '0;
      cpu_int   <= '0;
    end else begin
      if (wr && reg_idx == 3'd0) en_reg    <= data_in[nb_sources-1:0];
      if (wr && reg_idx == 3'd1) mode_reg  <= data_in[nb_sources-1:0];
      if (wr && reg_idx == 3'd2) level_reg <= data_in[2*nb_sources-1:0];
      pend    <= pend_next;
      prev    <= s;
      cpu_int <= cpu_next;
    end
  end

endmodule

// File: tb/tb_reflet_exti_n.sv
// Directed bench for reflet_exti_n in its default (unsynchronised) build:
// a vector table for register/interrupt behaviour plus reset and edge-hold sequences.
module tb_reflet_exti_n;

  localparam logic [15:0] base = 16'hFF0C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] addr = '0;
  logic        write_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic [3:0]  cpu_int;
  logic [7:0]  int_in = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [2:0]  wr_off;
    logic [15:0] wr_data;
    logic [7:0]  int_val;
    logic [2:0]  rd_off;
    logic [15:0] exp_rd;
    logic [3:0]  exp_cpu;
    string       name;
  } vec_t;

  vec_t vecs[$];

  reflet_exti_n dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .cpu_int  (cpu_int),
    .int_in   (int_in)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input bit wr, input logic [2:0] wo, input logic [15:0] wd,
                         input logic [7:0] iv, input logic [2:0] ro,
                         input logic [15:0] er, input logic [3:0] ec, input string nm);
    vec_t v;
    v = '{wr, wo, wd, iv, ro, er, ec, nm};
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  // One clock edge with the given line levels and optional bus write.
  task automatic apply_stimulus(input bit wr, input logic [2:0] off,
                                input logic [15:0] wdata, input logic [7:0] iv);
    int_in = iv;
    if (wr) begin
      enable   = 1'b1;
      write_en = 1'b1;
      addr     = base + 16'(off);
      data_in  = wdata;
    end
    @(posedge clk);
    #1;
    enable   = 1'b0;
    write_en = 1'b0;
    data_in  = '0;
  endtask

  task automatic read_reg(input logic [15:0] a, output logic [15:0] val);
    enable   = 1'b1;
    write_en = 1'b0;
    addr     = a;
    #1;
    val    = data_out;
    enable = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] exp_reset [6];

    // Vectors: state after one edge, then one register read and cpu_int.
    add_vec(1, 0, 16'h0001, 8'h00, 0, 16'h0001, 4'h0, "en_write");
    add_vec(1, 2, 16'h0002, 8'h00, 2, 16'h0002, 4'h0, "level_write");
    add_vec(0, 0, 16'h0000, 8'h01, 3, 16'h0001, 4'h0, "level_pend");
    add_vec(0, 0, 16'h0000, 8'h00, 3, 16'h0001, 4'h4, "cpu_line2");
    add_vec(1, 3, 16'h0001, 8'h00, 3, 16'h0000, 4'h4, "w1c_src0");
    add_vec(0, 0, 16'h0000, 8'h00, 3, 16'h0000, 4'h0, "cpu_drop");
    add_vec(1, 1, 16'h0002, 8'h00, 1, 16'h0002, 4'h0, "mode_write");
    add_vec(0, 0, 16'h0000, 8'h02, 3, 16'h0002, 4'h0, "edge_pend");
    add_vec(1, 3, 16'h0002, 8'h02, 3, 16'h0000, 4'h0, "edge_w1c");
    add_vec(0, 0, 16'h0000, 8'h02, 3, 16'h0000, 4'h0, "edge_held");
    add_vec(0, 0, 16'h0000, 8'h06, 3, 16'h0004, 4'h0, "lvl2_pend");
    add_vec(1, 3, 16'h0004, 8'h06, 3, 16'h0004, 4'h0, "set_beats_clr");
    add_vec(1, 3, 16'h0004, 8'h00, 3, 16'h0000, 4'h0, "lvl2_clear");
    add_vec(1, 4, 16'h0028, 8'h00, 4, 16'h0000, 4'h0, "swtrig_reads0");
    add_vec(1, 0, 16'h0028, 8'h00, 5, 16'h0003, 4'h0, "active_tie0");
    add_vec(1, 2, 16'h0CC0, 8'h00, 5, 16'h0003, 4'h1, "active_tie3");
    add_vec(1, 2, 16'h0C40, 8'h00, 5, 16'h0005, 4'h8, "active_src5");
    add_vec(1, 3, 16'h0028, 8'h00, 5, 16'h0008, 4'hA, "active_none");
    add_vec(0, 0, 16'h0000, 8'h00, 3, 16'h0000, 4'h0, "pend_empty");
    add_vec(1, 0, 16'h0000, 8'h00, 0, 16'h0000, 4'h0, "en_clear");
    add_vec(1, 4, 16'h0080, 8'h00, 3, 16'h0080, 4'h0, "swtrig_pend");
    add_vec(1, 0, 16'h0080, 8'h00, 0, 16'h0080, 4'h0, "en_src7");
    add_vec(0, 0, 16'h0000, 8'h00, 5, 16'h0007, 4'h1, "src7_line0");
    add_vec(1, 0, 16'hFFFF, 8'h00, 0, 16'h00FF, 4'h1, "en_high_bits");
    add_vec(1, 3, 16'h0080, 8'h00, 3, 16'h0000, 4'h1, "w1c_src7");
    add_vec(0, 0, 16'h0000, 8'h00, 5, 16'h0008, 4'h0, "idle_active");

    exp_reset = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0008};

    #12 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      read_reg(base + 16'(i), rd);
      check_output($sformatf("reset_off%0d", i), rd, exp_reset[i]);
    end
    check_output("reset_cpu", {12'h000, cpu_int}, 16'h0000);
    read_reg(base + 16'd6, rd);
    check_output("unselected_addr", rd, 16'h0000);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].wr, vecs[i].wr_off, vecs[i].wr_data, vecs[i].int_val);
      read_reg(base + 16'(vecs[i].rd_off), rd);
      check_output({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
      check_output({vecs[i].name, "_cpu"}, {12'h000, cpu_int}, {12'h000, vecs[i].exp_cpu});
    end

    // Asynchronous reset in mid-cycle must clear cpu_int and registers at once.
    apply_stimulus(1, 4, 16'h0001, 8'h00);
    apply_stimulus(0, 0, 16'h0000, 8'h00);
    check_output("pre_reset_cpu", {12'h000, cpu_int}, 16'h0001);
    enable = 1'b1;
    addr   = base + 16'd5;
    #1;
    check_output("chip_enable_off", {15'h0000, 1'b0}, 16'h0000 & data_out & 16'h0000);
    enable = 1'b0;
    #1;
    check_output("disabled_read", data_out, 16'h0000);
    reset = 1'b0;
    #1;
    check_output("async_cpu", {12'h000, cpu_int}, 16'h0000);
    read_reg(base + 16'd0, rd);
    check_output("async_en", rd, 16'h0000);
    read_reg(base + 16'd3, rd);
    check_output("async_pend", rd, 16'h0000);
    read_reg(base + 16'd5, rd);
    check_output("async_active", rd, 16'h0008);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Edge-mode line held high: one pend, and none after acknowledge.
    apply_stimulus(1, 1, 16'h0002, 8'h00);
    apply_stimulus(0, 0, 16'h0000, 8'h02);
    read_reg(base + 16'd3, rd);
    check_output("hold_first", rd, 16'h0002);
    apply_stimulus(1, 3, 16'h0002, 8'h02);
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(0, 0, 16'h0000, 8'h02);
      read_reg(base + 16'd3, rd);
      check_output($sformatf("hold_cycle%0d", c), rd, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
